// File: rtl/lib_operation_pkg.sv
// Shared stage-sequencing definitions: classic stage indices, default sizing and next-stage helper.
package lib_operation;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        DECODE   = 2'd1,
        EXECUTE  = 2'd2,
        MEMSTORE = 2'd3
    } stage_e;

    localparam int unsigned DEF_N_STAGES = 4;
    localparam int unsigned DEF_CNT_W    = 8;
    localparam int unsigned PERF_CNT_W   = 32;

    // Stage reached by an advance from a legal stage; 0 means the instruction retires.
    function automatic int unsigned next_stage_idx(
        input int unsigned stage,
        input int unsigned n,
        input logic        skip,
        input int unsigned skip_from
    );
        if (stage >= n - 1)                   return 0;
        else if (skip && (stage == skip_from)) return 0;
        else                                  return stage + 1;
    endfunction

    function automatic logic stage_legal(input int unsigned stage, input int unsigned n);
        return stage < n;
    endfunction

endpackage

// File: rtl/stage_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds when neither clear nor increment is asserted.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Clear wins over increment; increment stops at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/stage_sequencer.sv
// Parametrised multicycle stage controller: walks N_STAGES stages with stall, early retire and flush.
// Optional performance counters enabled by defining STAGE_SEQUENCER_PERF_EN.
module stage_sequencer
    import lib_operation::*;
#(
    parameter int unsigned N_STAGES  = DEF_N_STAGES,
    parameter int unsigned SKIP_FROM = 32'(EXECUTE),
    parameter int unsigned CNT_W     = DEF_CNT_W,
    localparam int unsigned STAGE_W  = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_stall,
    input  logic                  i_done,
    input  logic                  i_skip,
    input  logic                  i_flush,
    output logic [STAGE_W-1:0]    o_stage,
    output logic [N_STAGES-1:0]   o_stage_oh,
    output logic                  o_enter,
    output logic                  o_retire,
    output logic [CNT_W-1:0]      o_stage_cycles,
    output logic [PERF_CNT_W-1:0] o_instr_cnt,
    output logic [PERF_CNT_W-1:0] o_stall_cnt
);

    logic [STAGE_W-1:0]  r_stage;
    logic [N_STAGES-1:0] r_stage_oh;
    logic                r_enter;
    logic                r_retire;

    logic [STAGE_W-1:0]  w_stage_nxt;
    logic [STAGE_W-1:0]  w_adv_idx;
    logic                w_legal;
    logic                w_enter_nxt;
    logic                w_retire_nxt;
    logic                w_cnt_clr;
    logic                w_cnt_inc;

    assign w_legal   = stage_legal(32'(r_stage), N_STAGES);
    assign w_adv_idx = STAGE_W'(next_stage_idx(32'(r_stage), N_STAGES, i_skip, SKIP_FROM));

    // State register: stage index with its one-hot and entry/retire flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage    <= '0;
            r_stage_oh <= N_STAGES'(1);
            r_enter    <= 1'b1;
            r_retire   <= 1'b0;
        end else begin
            r_stage    <= w_stage_nxt;
            r_stage_oh <= N_STAGES'(1) << w_stage_nxt;
            r_enter    <= w_enter_nxt;
            r_retire   <= w_retire_nxt;
        end
    end

    // Next-state: illegal index recovery, then flush > stall > advance > hold, all gated by i_en.
    always_comb begin
        w_stage_nxt  = r_stage;
        w_enter_nxt  = 1'b0;
        w_retire_nxt = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        if (!w_legal) begin
            w_stage_nxt = '0;
            w_enter_nxt = 1'b1;
            w_cnt_clr   = 1'b1;
        end else if (i_en) begin
            if (i_flush) begin
                w_stage_nxt = '0;
                w_enter_nxt = 1'b1;
                w_cnt_clr   = 1'b1;
            end else if (i_stall) begin
                w_cnt_inc = 1'b1;
            end else if (i_done) begin
                w_stage_nxt  = w_adv_idx;
                w_enter_nxt  = 1'b1;
                w_retire_nxt = (w_adv_idx == '0);
                w_cnt_clr    = 1'b1;
            end else begin
                w_cnt_inc = 1'b1;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stage_cycles (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_cnt_clr),
        .i_inc (w_cnt_inc),
        .o_cnt (o_stage_cycles)
    );

`ifdef STAGE_SEQUENCER_PERF_EN
    logic [PERF_CNT_W-1:0] r_instr_cnt;
    logic [PERF_CNT_W-1:0] r_stall_cnt;
    logic                  w_stall_evt;

    assign w_stall_evt = w_legal & i_en & ~i_flush & i_stall;

    // Free-running 32-bit event counters; wrap silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_retire_nxt) r_instr_cnt <= r_instr_cnt + PERF_CNT_W'(1);
            if (w_stall_evt)  r_stall_cnt <= r_stall_cnt + PERF_CNT_W'(1);
        end
    end

    assign o_instr_cnt = r_instr_cnt;
    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_instr_cnt = '0;
    assign o_stall_cnt = '0;
`endif

    assign o_stage    = r_stage;
    assign o_stage_oh = r_stage_oh;
    assign o_enter    = r_enter;
    assign o_retire   = r_retire;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: default 4-stage instance plus a 6-stage, 3-bit-counter instance.
module tb_stage_sequencer;

`ifdef STAGE_SEQUENCER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst_n;

    logic        d_en, d_stall, d_done, d_skip, d_flush;
    logic [1:0]  d_stage;
    logic [3:0]  d_oh;
    logic        d_enter, d_retire;
    logic [7:0]  d_cyc;
    logic [31:0] d_instr, d_stallc;

    logic        e_en, e_stall, e_done, e_skip, e_flush;
    logic [2:0]  e_stage;
    logic [5:0]  e_oh;
    logic        e_enter, e_retire;
    logic [2:0]  e_cyc;
    logic [31:0] e_instr, e_stallc;

    int checks = 0;
    int errors = 0;

    stage_sequencer dut (
        .clk(clk), .rst_n(rst_n), .i_en(d_en), .i_stall(d_stall), .i_done(d_done),
        .i_skip(d_skip), .i_flush(d_flush), .o_stage(d_stage), .o_stage_oh(d_oh),
        .o_enter(d_enter), .o_retire(d_retire), .o_stage_cycles(d_cyc),
        .o_instr_cnt(d_instr), .o_stall_cnt(d_stallc)
    );

    stage_sequencer #(.N_STAGES(6), .SKIP_FROM(2), .CNT_W(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .i_en(e_en), .i_stall(e_stall), .i_done(e_done),
        .i_skip(e_skip), .i_flush(e_flush), .o_stage(e_stage), .o_stage_oh(e_oh),
        .o_enter(e_enter), .o_retire(e_retire), .o_stage_cycles(e_cyc),
        .o_instr_cnt(e_instr), .o_stall_cnt(e_stallc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {d_en, d_stall, d_done, d_skip, d_flush} = '0;
        {e_en, e_stall, e_done, e_skip, e_flush} = '0;
        #12;
        chk("rst_stage", 32'(d_stage), 0);
        chk("rst_oh", 32'(d_oh), 1);
        chk("rst_enter", 32'(d_enter), 1);
        chk("rst_retire", 32'(d_retire), 0);
        chk("rst_cycles", 32'(d_cyc), 0);
        chk("rst_instr", d_instr, 0);
        chk("rst_stallc", d_stallc, 0);
        step();
        rst_n = 1'b1;

        // Free-running walk: one stage per edge, retire every 4th.
        d_en = 1'b1; d_done = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("walk_stage", 32'(d_stage), 32'((k + 1) % 4));
            chk("walk_oh", 32'(d_oh), 32'(1) << ((k + 1) % 4));
            chk("walk_enter", 32'(d_enter), 1);
            chk("walk_retire", 32'(d_retire), 32'((k % 4) == 3));
        end
        chk("walk_instr", d_instr, PERF ? 2 : 0);

        // Multi-cycle EXECUTE.
        step(); step();
        chk("mc_stage2", 32'(d_stage), 2);
        chk("mc_cyc0", 32'(d_cyc), 0);
        d_done = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("mc_hold_stage", 32'(d_stage), 2);
            chk("mc_hold_cyc", 32'(d_cyc), 32'(k));
            chk("mc_hold_enter", 32'(d_enter), 0);
        end
        d_done = 1'b1;
        step();
        chk("mc_adv_stage", 32'(d_stage), 3);
        chk("mc_adv_cyc", 32'(d_cyc), 0);
        chk("mc_adv_enter", 32'(d_enter), 1);
        step();
        chk("mc_ret", 32'(d_retire), 1);
        chk("mc_instr", d_instr, PERF ? 3 : 0);

        // Skip ignored in DECODE, honoured in EXECUTE.
        step();
        chk("sk_stage1", 32'(d_stage), 1);
        d_skip = 1'b1;
        step();
        chk("sk_ign_stage", 32'(d_stage), 2);
        chk("sk_ign_retire", 32'(d_retire), 0);
        step();
        chk("sk_stage", 32'(d_stage), 0);
        chk("sk_retire", 32'(d_retire), 1);
        chk("sk_instr", d_instr, PERF ? 4 : 0);
        d_skip = 1'b0;

        // Flush overrides stall and done.
        step();
        chk("fl_pre", 32'(d_stage), 1);
        d_stall = 1'b1; d_flush = 1'b1;
        step();
        chk("fl_stage", 32'(d_stage), 0);
        chk("fl_retire", 32'(d_retire), 0);
        chk("fl_enter", 32'(d_enter), 1);
        chk("fl_cyc", 32'(d_cyc), 0);
        chk("fl_stallc", d_stallc, 0);
        d_flush = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("st_stage", 32'(d_stage), 0);
            chk("st_enter", 32'(d_enter), 0);
            chk("st_cyc", 32'(d_cyc), 32'(k));
            chk("st_stallc", d_stallc, PERF ? 32'(k) : 0);
        end
        d_stall = 1'b0;
        step();
        chk("st_rel_stage", 32'(d_stage), 1);
        chk("st_rel_cyc", 32'(d_cyc), 0);
        step(); step(); step();
        chk("p5_retire", 32'(d_retire), 1);
        chk("p5_instr", d_instr, PERF ? 5 : 0);
        chk("p5_stallc", d_stallc, PERF ? 3 : 0);

        // Disable freezes state, squashes pulses and ignores flush.
        d_en = 1'b0; d_flush = 1'b1;
        step();
        chk("en0_stage", 32'(d_stage), 0);
        chk("en0_enter", 32'(d_enter), 0);
        chk("en0_retire", 32'(d_retire), 0);
        chk("en0_cyc", 32'(d_cyc), 0);
        d_flush = 1'b0;
        step();
        chk("en0_hold", 32'(d_stage), 0);
        chk("en0_instr", d_instr, PERF ? 5 : 0);
        d_en = 1'b1;
        step();
        chk("en1_stage", 32'(d_stage), 1);
        d_en = 1'b0; d_done = 1'b0;

        // Six-stage instance: saturation of 3-bit cycle counter, then full sweep.
        e_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("sat_cyc", 32'(e_cyc), (k > 7) ? 7 : 32'(k));
            chk("sat_stage", 32'(e_stage), 0);
        end
        e_done = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("n6_stage", 32'(e_stage), 32'((k + 1) % 6));
            chk("n6_oh", 32'(e_oh), 32'(1) << ((k + 1) % 6));
            chk("n6_retire", 32'(e_retire), 32'(k == 5));
            chk("n6_cyc", 32'(e_cyc), 0);
        end
        e_en = 1'b0;

        // Asynchronous reset mid-stage, sampled without a clock edge.
        d_en = 1'b1; d_done = 1'b1;
        step();
        chk("ar_pre_stage", 32'(d_stage), 2);
        d_done = 1'b0;
        step();
        chk("ar_pre_cyc", 32'(d_cyc), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_stage", 32'(d_stage), 0);
        chk("ar_oh", 32'(d_oh), 1);
        chk("ar_enter", 32'(d_enter), 1);
        chk("ar_retire", 32'(d_retire), 0);
        chk("ar_cyc", 32'(d_cyc), 0);
        chk("ar_instr", d_instr, 0);
        chk("ar_stallc", d_stallc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
